// File: rtl/pcx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcx_pkg
// Brief    : Shared types and constants for the PCX request buffer: data and
//            destination widths, destination one-hot codes, FIFO entry layout,
//            pairing-FSM state type and destination helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package pcx_pkg;

  localparam int PCX_DATA_W = 124;
  localparam int PCX_DEST_W = 5;

  // Destination one-hot codes: four L2 banks, then the IO bridge on bit 4.
  localparam logic [PCX_DEST_W-1:0] PCX_DEST_L2B0 = 5'b00001;
  localparam logic [PCX_DEST_W-1:0] PCX_DEST_L2B1 = 5'b00010;
  localparam logic [PCX_DEST_W-1:0] PCX_DEST_L2B2 = 5'b00100;
  localparam logic [PCX_DEST_W-1:0] PCX_DEST_L2B3 = 5'b01000;
  localparam logic [PCX_DEST_W-1:0] PCX_DEST_IO   = 5'b10000;

  // One buffered packet: destination, atomic-first flag and the data beat.
  typedef struct packed {
    logic [PCX_DEST_W-1:0] dest;
    logic                  atom;
    logic [PCX_DATA_W-1:0] data;
  } pcx_entry_t;

  localparam int PCX_ENTRY_W = $bits(pcx_entry_t);  // 130

  // Atomic pairing tracker: IDLE, or waiting for the second half of a pair.
  typedef enum logic [0:0] {
    PAIR_IDLE  = 1'b0,
    PAIR_ATOM2 = 1'b1
  } pair_state_t;

  // Isolate the lowest set bit of a request vector (two's-complement trick).
  function automatic logic [PCX_DEST_W-1:0] pcx_lowest_dest(
    input logic [PCX_DEST_W-1:0] req
  );
    return req & (~req + PCX_DEST_W'(1));
  endfunction

  // True when more than one destination bit is set.
  function automatic logic pcx_multi_dest(input logic [PCX_DEST_W-1:0] req);
    return (req & (req - PCX_DEST_W'(1))) != '0;
  endfunction

endpackage : pcx_pkg
`default_nettype wire

// File: rtl/pcx_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pcx_req_fifo
// Brief    : Generic synchronous FIFO with push/pop, occupancy count and
//            full/empty flags. A push while full is ignored, a pop while
//            empty is ignored. Head data is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module pcx_req_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 16,   // power of two
  parameter int AW    = 4     // log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_full    = (r_count == c_depth);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~w_full;
  assign w_pop_ok  = i_pop & ~w_empty;

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule : pcx_req_fifo
`default_nettype wire

// File: rtl/pcx_req_buf.sv
`default_nettype none
// ============================================================================
// Module   : pcx_req_buf
// Brief    : Terminates the SPARC core PCX request interface. Captures the
//            PQ-stage request, pairs it with the PA-stage data beat, buffers
//            packets in a FIFO and presents them downstream with valid/ready.
//            Atomic pairs are held until both halves are buffered. A grant
//            pulse is returned to the core one cycle after each pop.
//            Optional statistics (pkt_count, hiwater) are enabled by defining
//            PCX_REQ_BUF_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pcx_req_buf
  import pcx_pkg::*;
#(
  parameter int DEPTH = 16,   // power of two, >= 10 (5 dests x 2 outstanding)
  parameter int AW    = 4     // log2(DEPTH)
) (
  input  logic                  gclk,
  input  logic                  reset,
  input  logic [PCX_DEST_W-1:0] spc_pcx_req_pq,
  input  logic                  spc_pcx_atom_pq,
  input  logic [PCX_DATA_W-1:0] spc_pcx_data_pa,
  output logic [PCX_DEST_W-1:0] pcx_spc_grant_px,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PCX_DATA_W-1:0] out_data,
  output logic [PCX_DEST_W-1:0] out_dest,
  output logic                  out_atom,
  output logic [AW:0]           occupancy,
  output logic                  proto_err,
  output logic                  ovf_err
`ifdef PCX_REQ_BUF_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [AW:0]           hiwater
`endif
);

  localparam logic [AW:0] c_pair_min = (AW+1)'(2);

  // PQ-stage request decode
  logic                  w_req_any;
  logic                  w_req_multi;
  logic [PCX_DEST_W-1:0] w_req_dest;

  // PA-stage capture register
  logic                  r_pa_valid;
  logic [PCX_DEST_W-1:0] r_pa_dest;
  logic                  r_pa_atom;

  // FIFO interface
  pcx_entry_t            w_push_entry;
  logic [PCX_ENTRY_W-1:0] w_rdata;
  pcx_entry_t            w_head;
  logic [AW:0]           w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_ok;
  logic                  w_pop;

  // Pairing FSM, sticky flags and grant
  pair_state_t           r_state;
  logic                  r_proto_err;
  logic                  r_ovf_err;
  logic [PCX_DEST_W-1:0] r_grant;

  assign w_req_any   = |spc_pcx_req_pq;
  assign w_req_multi = pcx_multi_dest(spc_pcx_req_pq);
  assign w_req_dest  = pcx_lowest_dest(spc_pcx_req_pq);

  // Register the request so it lines up with its data beat one cycle later.
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_pa_valid <= 1'b0;
      r_pa_dest  <= '0;
      r_pa_atom  <= 1'b0;
    end else begin
      r_pa_valid <= w_req_any;
      r_pa_dest  <= w_req_dest;
      r_pa_atom  <= spc_pcx_atom_pq & w_req_any;
    end
  end

  assign w_push_entry.dest = r_pa_dest;
  assign w_push_entry.atom = r_pa_atom;
  assign w_push_entry.data = spc_pcx_data_pa;

  pcx_req_fifo #(
    .WIDTH (PCX_ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (gclk),
    .rst     (reset),
    .i_push  (r_pa_valid),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = w_rdata;

  // An atomic head waits for its partner so both halves leave back to back.
  assign w_head_ok = ~w_empty & (~w_head.atom | (w_count >= c_pair_min));
  assign w_pop     = w_head_ok & out_ready;

  assign out_valid = w_head_ok;
  assign out_data  = w_head_ok ? w_head.data : '0;
  assign out_dest  = w_head_ok ? w_head.dest : '0;
  assign out_atom  = w_head_ok ? w_head.atom : 1'b0;
  assign occupancy = w_count;

  // Pairing FSM: checks that an atomic first half is followed immediately by
  // a non-atomic second half; also flags multi-destination requests.
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_state     <= PAIR_IDLE;
      r_proto_err <= 1'b0;
    end else begin
      if (w_req_multi) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        PAIR_IDLE: begin
          if (w_req_any && spc_pcx_atom_pq) begin
            r_state <= PAIR_ATOM2;
          end
        end
        PAIR_ATOM2: begin
          if (!w_req_any || spc_pcx_atom_pq) begin
            r_proto_err <= 1'b1;
          end
          r_state <= PAIR_IDLE;
        end
        default: r_state <= PAIR_IDLE;
      endcase
    end
  end

  // Overflow is sticky; the dropped push itself is refused inside the FIFO.
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_ovf_err <= 1'b0;
    end else if (r_pa_valid && w_full) begin
      r_ovf_err <= 1'b1;
    end
  end

  // Grant pulse on the popped packet's destination, one cycle after the pop.
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_grant <= '0;
    end else begin
      r_grant <= w_pop ? w_head.dest : '0;
    end
  end

  assign pcx_spc_grant_px = r_grant;
  assign proto_err        = r_proto_err;
  assign ovf_err          = r_ovf_err;

`ifdef PCX_REQ_BUF_STATS_EN
  logic [31:0] r_pkt_count;
  logic [AW:0] r_hiwater;

  // Saturating pop counter and occupancy high-water mark.
  always_ff @(posedge gclk) begin
    if (reset) begin
      r_pkt_count <= '0;
      r_hiwater   <= '0;
    end else begin
      if (w_pop && (r_pkt_count != 32'hFFFF_FFFF)) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_count > r_hiwater) begin
        r_hiwater <= w_count;
      end
    end
  end

  assign pkt_count = r_pkt_count;
  assign hiwater   = r_hiwater;
`endif

endmodule : pcx_req_buf
`default_nettype wire

// File: tb/tb_pcx_req_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcx_req_buf
// Brief    : Self-checking bench for pcx_req_buf. Directed scenarios followed
//            by randomized traffic, compared every cycle against a queue-based
//            packet model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcx_req_buf;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          gclk = 1'b0;
  logic          reset;
  logic [4:0]    spc_pcx_req_pq;
  logic          spc_pcx_atom_pq;
  logic [123:0]  spc_pcx_data_pa;
  logic [4:0]    pcx_spc_grant_px;
  logic          out_valid;
  logic          out_ready;
  logic [123:0]  out_data;
  logic [4:0]    out_dest;
  logic          out_atom;
  logic [AW:0]   occupancy;
  logic          proto_err;
  logic          ovf_err;
`ifdef PCX_REQ_BUF_STATS_EN
  logic [31:0]   pkt_count;
  logic [AW:0]   hiwater;
`endif

  always #5 gclk = ~gclk;

  pcx_req_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .gclk             (gclk),
    .reset            (reset),
    .spc_pcx_req_pq   (spc_pcx_req_pq),
    .spc_pcx_atom_pq  (spc_pcx_atom_pq),
    .spc_pcx_data_pa  (spc_pcx_data_pa),
    .pcx_spc_grant_px (pcx_spc_grant_px),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_dest         (out_dest),
    .out_atom         (out_atom),
    .occupancy        (occupancy),
    .proto_err        (proto_err),
    .ovf_err          (ovf_err)
`ifdef PCX_REQ_BUF_STATS_EN
    ,
    .pkt_count        (pkt_count),
    .hiwater          (hiwater)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]   dest;
    logic         atom;
    logic [123:0] data;
  } pkt_t;

  pkt_t        m_q[$];        // packets buffered, head at index 0
  logic        m_pv;          // a request captured last cycle awaits its data
  logic [4:0]  m_pd;
  logic        m_pa;
  logic        m_wait_partner; // previous request opened an atomic pair
  logic [4:0]  m_grant;
  logic        m_proto;
  logic        m_ovf;
  longint      m_pkts;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_q.delete();
    m_pv = 1'b0; m_pd = '0; m_pa = 1'b0;
    m_wait_partner = 1'b0;
    m_grant = '0; m_proto = 1'b0; m_ovf = 1'b0;
    m_pkts = 0;
  endtask

  function automatic logic model_head_ok();
    if (m_q.size() == 0) return 1'b0;
    if (!m_q[0].atom)    return 1'b1;
    return m_q.size() >= 2;
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic pop;
    int   sz;
    pkt_t p;
    if (reset) begin
      model_reset();
    end else begin
      sz  = m_q.size();
      pop = model_head_ok() && out_ready;
      m_grant = pop ? m_q[0].dest : 5'b0;
      if (pop) begin
        void'(m_q.pop_front());
        m_pkts++;
      end
      if (m_pv) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else begin
          p.dest = m_pd; p.atom = m_pa; p.data = spc_pcx_data_pa;
          m_q.push_back(p);
        end
      end
      m_pv = (spc_pcx_req_pq != 0);
      m_pd = '0;
      for (int b = 0; b < 5; b++)
        if (spc_pcx_req_pq[b] && m_pd == 0) m_pd = 5'(1 << b);
      m_pa = spc_pcx_atom_pq && m_pv;
      if ($countones(spc_pcx_req_pq) > 1) m_proto = 1'b1;
      if (m_wait_partner) begin
        if (!m_pv || spc_pcx_atom_pq) m_proto = 1'b1;
        m_wait_partner = 1'b0;
      end else if (m_pv && spc_pcx_atom_pq) begin
        m_wait_partner = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = model_head_ok();
    chk("out_valid", 128'(out_valid), 128'(ev));
    chk("out_dest",  128'(out_dest),  ev ? 128'(m_q[0].dest) : 128'(0));
    chk("out_atom",  128'(out_atom),  ev ? 128'(m_q[0].atom) : 128'(0));
    chk("out_data",  128'(out_data),  ev ? 128'(m_q[0].data) : 128'(0));
    chk("occupancy", 128'(occupancy), 128'(m_q.size()));
    chk("grant",     128'(pcx_spc_grant_px), 128'(m_grant));
    chk("proto_err", 128'(proto_err), 128'(m_proto));
    chk("ovf_err",   128'(ovf_err),   128'(m_ovf));
`ifdef PCX_REQ_BUF_STATS_EN
    chk("pkt_count", 128'(pkt_count), 128'(m_pkts));
`endif
  endtask

  function automatic logic [123:0] rnd_data();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[123:0];
  endfunction

  // Drive one cycle of inputs, check outputs at the falling edge, then clock.
  task automatic step(input logic [4:0] req, input logic atom, input logic rdy,
                      input logic [123:0] data, input logic rst);
    spc_pcx_req_pq  = req;
    spc_pcx_atom_pq = atom;
    out_ready       = rdy;
    spc_pcx_data_pa = data;
    reset           = rst;
    @(negedge gclk);
    check_outputs();
    model_edge();
    @(posedge gclk);
    #1;
  endtask

  logic [123:0] a5;
  logic [4:0]   rq;
  int           r;

  initial begin
    a5 = {4'hA, {15{8'hA5}}};
    // initial reset, no checks until the model is anchored
    reset = 1'b1; spc_pcx_req_pq = '0; spc_pcx_atom_pq = 1'b0;
    spc_pcx_data_pa = '0; out_ready = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    model_reset();
    step(5'b0, 1'b0, 1'b0, '0, 1'b1);
    step(5'b0, 1'b0, 1'b0, '0, 1'b1);

    // single store
    step(5'b00001, 1'b0, 1'b1, rnd_data(), 1'b0);
    step(5'b00000, 1'b0, 1'b1, a5, 1'b0);
    repeat (4) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    // back-to-back to four banks with downstream stalled, then drain
    step(5'b00001, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b00010, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b00100, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b01000, 1'b0, 1'b0, rnd_data(), 1'b0);
    repeat (2) step(5'b0, 1'b0, 1'b0, rnd_data(), 1'b0);
    repeat (6) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    // well-formed atomic pair
    step(5'b00100, 1'b1, 1'b1, rnd_data(), 1'b0);
    step(5'b00100, 1'b0, 1'b1, rnd_data(), 1'b0);
    repeat (5) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    // broken atomic: first half followed by idle, partner arrives later
    step(5'b00010, 1'b1, 1'b1, rnd_data(), 1'b0);
    repeat (3) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);
    step(5'b10000, 1'b0, 1'b1, rnd_data(), 1'b0);
    repeat (5) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    // multi-destination request keeps lowest bit
    step(5'b01100, 1'b0, 1'b1, rnd_data(), 1'b0);
    repeat (3) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);
    step(5'b0, 1'b0, 1'b0, '0, 1'b1);

    // overflow: 17 requests with downstream stalled, then drain
    for (int i = 0; i < 17; i++)
      step(5'(1 << (i % 5)), 1'b0, 1'b0, rnd_data(), 1'b0);
    repeat (2) step(5'b0, 1'b0, 1'b0, rnd_data(), 1'b0);
    repeat (20) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    // reset with three entries buffered
    step(5'b00001, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b00010, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b00100, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b0, 1'b0, 1'b0, rnd_data(), 1'b0);
    step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b1);
    repeat (3) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      rq = 5'b0;
      else if (r < 9) rq = 5'(1 << $urandom_range(0, 4));
      else            rq = 5'($urandom);
      step(rq, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
           rnd_data(), ($urandom_range(0, 249) == 0));
    end
    repeat (24) step(5'b0, 1'b0, 1'b1, rnd_data(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pcx_req_buf
`default_nettype wire

// File: doc/pcx_req_buf.md
Name: pcx_req_buf

Overview:
- Downstream neighbour of the single-core SPARC wrapper. It terminates the core's PCX request interface: spc_pcx_req_pq, spc_pcx_atom_pq and spc_pcx_data_pa.
- Pairs each request with its data beat, buffers packets in a FIFO and presents them to the memory/bridge side with a valid/ready handshake.
- Returns pcx_spc_grant_px to the core as each packet leaves the buffer.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and >= 10 (5 destinations x 2 outstanding).
- AW, 4, pointer width = log2(DEPTH).

Ports:
- gclk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- spc_pcx_req_pq  in  5  one-hot destination request (PQ stage).
- spc_pcx_atom_pq  in  1  first half of an atomic pair; qualified by a nonzero req.
- spc_pcx_data_pa  in  124  packet data, valid the cycle after req (PA stage).
- pcx_spc_grant_px  out  5  one-cycle grant pulse per dequeued packet, on that packet's destination bit.
- out_valid  out  1  head packet available.
- out_ready  in  1  downstream accepts head.
- out_data  out  124  head packet data.
- out_dest  out  5  head packet destination, one-hot.
- out_atom  out  1  head is the first of an atomic pair.
- occupancy  out  AW+1  entries currently stored.
- proto_err  out  1  sticky protocol-violation flag.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset values:
  - all outputs 0; occupancy 0;
  - FIFO pointers 0;
  - pairing FSM in IDLE;
  - PA capture register invalid.
- Capture:
  - If req_pq != 0 in cycle t, register {dest = req, atom} into stage PA.
  - In cycle t+1, push {dest, atom, spc_pcx_data_pa} into the FIFO.
  - Capture latency: 1 cycle. A back-to-back req every cycle is sustained.
- Destination encoding: if req has more than one bit set, set proto_err and keep only the lowest set bit.
- Pairing FSM:
  - IDLE: a req with atom=1 goes to ATOM2.
  - ATOM2: the next cycle must carry req != 0 with atom=0, then return to IDLE.
  - In ATOM2, req == 0 or atom=1 sets proto_err and returns to IDLE. In the atom=1 case the new packet is still captured.
- Output:
  - out_valid = FIFO non-empty.
  - Exception: if the head has atom=1, out_valid is held low until its partner entry is also present, so the pair is presented on consecutive cycles.
  - The head is popped when out_valid & out_ready.
- Grant: on a pop in cycle t, pcx_spc_grant_px = that packet's dest during cycle t+1 (registered); otherwise 0. An atomic pair yields two grants on consecutive cycles when ready is held high.
- Simultaneous push and pop: occupancy unchanged. Pop of an empty FIFO cannot occur (out_valid gates it).
- Full FIFO:
  - A push while full is dropped and sets ovf_err.
  - Unreachable with a compliant core and DEPTH >= 10.
- Pointers: wrap modulo DEPTH; full/empty derived from occupancy.
- Sticky flags: cleared only by reset.
- Reset mid-operation: all buffered and in-flight packets are discarded. No grant is issued for them.

Optional Feature:
- PCX_REQ_BUF_STATS_EN
- Defined: adds output pkt_count[31:0].
  - Increments on every pop and saturates at 0xFFFFFFFF.
  - Reset to 0.
  - Also adds output hiwater[AW:0], the maximum occupancy seen since reset.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Shared package pcx_pkg:
  - PCX_DATA_W=124, PCX_DEST_W=5;
  - the destination one-hot constants (L2 banks 0-3, IO=bit 4);
  - the FIFO entry struct/width (130 bits).
- One sub-module pcx_req_fifo: a generic synchronous FIFO with push, pop, count and full/empty, parameterised by width and depth.
- Capture stage, pairing FSM and grant logic stay in pcx_req_buf.

Test Plan:
- Single store: req=5'b00001 at t, data=124'hA5.. at t+1, out_ready=1 -> out_valid at t+2 with out_dest=00001, out_data=A5..; grant=00001 at t+3; occupancy returns to 0.
- Back-to-back: 4 reqs to dests 00001, 00010, 00100, 01000 on consecutive cycles, out_ready=0 -> occupancy=4. Then raise ready -> 4 pops in order, grants 00001, 00010, 00100, 01000 on consecutive cycles.
- Atomic: req=00100 atom=1, then req=00100 atom=0 -> out_valid stays low until both entries are stored; out_atom=1 on the first pop; two grants of 00100 on consecutive cycles; proto_err=0.
- Broken atomic: atom=1 followed by an idle cycle -> proto_err=1, FSM back to IDLE, first packet still delivered with out_atom=1 once a following entry arrives.
- Overflow with DEPTH=16, out_ready=0: 17 requests -> occupancy=16, ovf_err=1, the 17th packet never appears at the output.
- Reset mid-stream with 3 entries buffered -> next cycle occupancy=0, out_valid=0, grant=0, proto_err=ovf_err=0.
